// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the scoreboarded register file (regfile_sb).
//   - DATA_W_DEF / ADDR_W_DEF : default register width and address width.
//   - zero_reg_idx()          : index of the hardwired zero register for a
//                               given address width (the highest address).
// ----------------------------------------------------------------------------
package regfile_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 5;

  // The zero register sits at the top of the address space.
  function automatic int zero_reg_idx(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// ----------------------------------------------------------------------------
// regfile_sb_if
//   Bundle of the write, reserve and read-port signals of regfile_sb.
//   Signals:
//     write / wrAddr / wrData   : write request (data store + busy clear)
//     rsvValid / rsvAddr        : reserve request (busy set)
//     rdAddrA / rdAddrB         : read addresses
//     rdDataA / rdDataB         : read data (combinational)
//     rdBusyA / rdBusyB         : busy flag of the addressed register
//   Modports:
//     master : the user of the register file (drives requests, reads data)
//     slave  : the register file itself
//
//   Handshake semantics: there is no backpressure. write and rsvValid are
//   single-cycle request strobes that are always accepted on the rising
//   edge at which they are high; there is no ready signal and nothing is
//   held over to a later cycle. Read ports are pure combinational lookups.
// ----------------------------------------------------------------------------
interface regfile_sb_if import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              write;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              rsvValid;
  logic [ADDR_W-1:0] rsvAddr;
  logic [ADDR_W-1:0] rdAddrA;
  logic [ADDR_W-1:0] rdAddrB;
  logic [DATA_W-1:0] rdDataA;
  logic [DATA_W-1:0] rdDataB;
  logic              rdBusyA;
  logic              rdBusyB;

  modport master (
    output write, wrAddr, wrData,
    output rsvValid, rsvAddr,
    output rdAddrA, rdAddrB,
    input  rdDataA, rdDataB,
    input  rdBusyA, rdBusyB
  );

  modport slave (
    input  write, wrAddr, wrData,
    input  rsvValid, rsvAddr,
    input  rdAddrA, rdAddrB,
    output rdDataA, rdDataB,
    output rdBusyA, rdBusyB
  );

endinterface

// File: rtl/regfile_sb_rdport.sv
// ----------------------------------------------------------------------------
// regfile_sb_rdport
//   One combinational read port of regfile_sb: data mux, busy lookup,
//   zero-register override and (optionally) write-to-read forwarding.
//   Ports:
//     i_addr     : read address
//     i_mem      : all stored registers (packed, index = address)
//     i_busy     : all busy bits (index = address)
//     i_write    : current write strobe        (REGFILE_BYPASS_EN only)
//     i_wr_addr  : current write address       (REGFILE_BYPASS_EN only)
//     i_wr_data  : current write data          (REGFILE_BYPASS_EN only)
//     o_data     : read data
//     o_busy     : busy flag of the addressed register
//   Configuration macro: REGFILE_BYPASS_EN -- when defined, a write in the
//   current cycle to the addressed register is forwarded to o_data and
//   reports not-busy in the same cycle.
// ----------------------------------------------------------------------------
module regfile_sb_rdport import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int HAS_ZR = 1
) (
  input  logic [ADDR_W-1:0]                   i_addr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    i_mem,
  input  logic [2**ADDR_W-1:0]                i_busy,
`ifdef REGFILE_BYPASS_EN
  input  logic                                i_write,
  input  logic [ADDR_W-1:0]                   i_wr_addr,
  input  logic [DATA_W-1:0]                   i_wr_data,
`endif
  output logic [DATA_W-1:0]                   o_data,
  output logic                                o_busy
);

  localparam logic [ADDR_W-1:0] ZR_ADDR = ADDR_W'(zero_reg_idx(ADDR_W));

  logic w_is_zr;

  assign w_is_zr = (HAS_ZR != 0) && (i_addr == ZR_ADDR);

  always_comb begin
    o_data = i_mem[i_addr];
    o_busy = i_busy[i_addr];
`ifdef REGFILE_BYPASS_EN
    // The value being written this cycle is the one the register will hold
    // next cycle, and the write retires any outstanding reservation.
    if (i_write && (i_wr_addr == i_addr)) begin
      o_data = i_wr_data;
      o_busy = 1'b0;
    end
`endif
    // Zero register overrides everything, including forwarding.
    if (w_is_zr) begin
      o_data = '0;
      o_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb
//   Register file with a per-register busy (scoreboard) bit.
//   2**ADDR_W registers of DATA_W bits, one write port, one reserve port and
//   two independent combinational read ports.
//   - A write stores wrData and clears the busy bit of wrAddr.
//   - A reserve sets the busy bit of rsvAddr. If a write and a reserve hit
//     the same register on one edge, the data is stored and the register
//     stays busy (the reserve belongs to a newer producer).
//   - With HAS_ZR=1 the highest address reads 0 / not-busy and ignores
//     writes and reserves.
//   Ports:
//     clk  : clock, all state changes on the rising edge
//     rst  : asynchronous, active-high reset (clears data and busy bits)
//     bus  : regfile_sb_if.slave (write, reserve and read-port signals)
//   Configuration macro: REGFILE_BYPASS_EN -- forward same-cycle write data
//   to the read ports (see regfile_sb_rdport). Undefined by default: reads
//   return stored state only, with one cycle of write-to-read latency.
// ----------------------------------------------------------------------------
module regfile_sb import regfile_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int HAS_ZR = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_sb_if.slave  bus
);

  localparam int                DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZR_ADDR = ADDR_W'(zero_reg_idx(ADDR_W));

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0]             r_busy;

  logic w_wr_en;
  logic w_rsv_en;

  // Requests aimed at the zero register are dropped here so its storage
  // never changes from the reset value.
  assign w_wr_en  = bus.write    && !((HAS_ZR != 0) && (bus.wrAddr  == ZR_ADDR));
  assign w_rsv_en = bus.rsvValid && !((HAS_ZR != 0) && (bus.rsvAddr == ZR_ADDR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem  <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[bus.wrAddr]  <= bus.wrData;
        r_busy[bus.wrAddr] <= 1'b0;
      end
      // Placed after the write so a same-address reserve wins the busy bit.
      if (w_rsv_en) begin
        r_busy[bus.rsvAddr] <= 1'b1;
      end
    end
  end

  regfile_sb_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .HAS_ZR (HAS_ZR)
  ) u_rd_a (
    .i_addr    (bus.rdAddrA),
    .i_mem     (r_mem),
    .i_busy    (r_busy),
`ifdef REGFILE_BYPASS_EN
    .i_write   (bus.write),
    .i_wr_addr (bus.wrAddr),
    .i_wr_data (bus.wrData),
`endif
    .o_data    (bus.rdDataA),
    .o_busy    (bus.rdBusyA)
  );

  regfile_sb_rdport #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .HAS_ZR (HAS_ZR)
  ) u_rd_b (
    .i_addr    (bus.rdAddrB),
    .i_mem     (r_mem),
    .i_busy    (r_busy),
`ifdef REGFILE_BYPASS_EN
    .i_write   (bus.write),
    .i_wr_addr (bus.wrAddr),
    .i_wr_data (bus.wrData),
`endif
    .o_data    (bus.rdDataB),
    .o_busy    (bus.rdBusyB)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_sb
//   Self-checking bench for regfile_sb (DATA_W=64, ADDR_W=5, HAS_ZR=1).
//   A behavioural model (plain arrays) tracks register contents and busy
//   bits; a compare process checks both read ports against it on every
//   falling edge. Directed scenarios add literal expectations through an
//   expected-value queue, followed by randomized traffic.
// ----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NREG = 32;
  localparam int ZR = 31;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_sb #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .HAS_ZR (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pop_check(input string name, input logic [DW-1:0] act);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: expected queue empty, got %h", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_mem  [NREG];
  logic          m_busy [NREG];

  initial begin
    for (int a = 0; a < NREG; a++) begin
      m_mem[a]  = '0;
      m_busy[a] = 1'b0;
    end
  end

  // Per register: data follows a write; busy ends 1 if reserved, else 0 if
  // written, else unchanged. The zero register never changes.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < NREG; a++) begin
        m_mem[a]  <= '0;
        m_busy[a] <= 1'b0;
      end
    end else begin
      for (int a = 0; a < NREG; a++) begin
        if (a != ZR) begin
          if (bus.write && (bus.wrAddr == 5'(a))) m_mem[a] <= bus.wrData;
          if (bus.rsvValid && (bus.rsvAddr == 5'(a))) m_busy[a] <= 1'b1;
          else if (bus.write && (bus.wrAddr == 5'(a))) m_busy[a] <= 1'b0;
        end
      end
    end
  end

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (int'(a) == ZR) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.write && (bus.wrAddr == a)) return bus.wrData;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (int'(a) == ZR) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus.write && (bus.wrAddr == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model rdDataA", bus.rdDataA, exp_data(bus.rdAddrA));
      check("model rdDataB", bus.rdDataB, exp_data(bus.rdAddrB));
      check("model rdBusyA", {63'd0, bus.rdBusyA}, {63'd0, exp_busy(bus.rdAddrA)});
      check("model rdBusyB", {63'd0, bus.rdBusyB}, {63'd0, exp_busy(bus.rdAddrB)});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.write    = 1'b0;
    bus.wrAddr   = '0;
    bus.wrData   = '0;
    bus.rsvValid = 1'b0;
    bus.rsvAddr  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 5'(ZR);
    if (r < 5)  return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, NREG - 1));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    idle();
    bus.rdAddrA = '0;
    bus.rdAddrB = '0;
    #1 rst = 1'b1;
    #1 cmp_en = 1'b1;

    // Reset state
    @(negedge clk);
    exp_q.push_back('0); pop_check("reset rdDataA", bus.rdDataA);
    exp_q.push_back('0); pop_check("reset rdBusyB", {63'd0, bus.rdBusyB});
    @(negedge clk);
    rst = 1'b0;

    // Write then read on both ports
    next_cycle();
    bus.write = 1'b1; bus.wrAddr = 5'd3; bus.wrData = 64'hDEADBEEF_00000001;
    bus.rdAddrA = 5'd3; bus.rdAddrB = 5'd3;
    next_cycle();
    idle();
    @(negedge clk);
    exp_q.push_back(64'hDEADBEEF_00000001); pop_check("wr3 rdDataA", bus.rdDataA);
    exp_q.push_back(64'hDEADBEEF_00000001); pop_check("wr3 rdDataB", bus.rdDataB);
    exp_q.push_back('0); pop_check("wr3 rdBusyA", {63'd0, bus.rdBusyA});
    exp_q.push_back('0); pop_check("wr3 rdBusyB", {63'd0, bus.rdBusyB});

    // Reserve addr 7, write it two cycles later
    next_cycle();
    bus.rsvValid = 1'b1; bus.rsvAddr = 5'd7; bus.rdAddrA = 5'd7;
    next_cycle();
    idle();
    @(negedge clk);
    exp_q.push_back(64'd1); pop_check("rsv7 rdBusyA", {63'd0, bus.rdBusyA});
    next_cycle();
    bus.write = 1'b1; bus.wrAddr = 5'd7; bus.wrData = 64'h55;
    next_cycle();
    idle();
    @(negedge clk);
    exp_q.push_back('0);    pop_check("wr7 rdBusyA", {63'd0, bus.rdBusyA});
    exp_q.push_back(64'h55); pop_check("wr7 rdDataA", bus.rdDataA);

    // Write + reserve collision on addr 9
    next_cycle();
    bus.write = 1'b1; bus.wrAddr = 5'd9; bus.wrData = 64'hAA;
    bus.rsvValid = 1'b1; bus.rsvAddr = 5'd9; bus.rdAddrA = 5'd9;
    next_cycle();
    idle();
    @(negedge clk);
    exp_q.push_back(64'hAA); pop_check("coll9 rdDataA", bus.rdDataA);
    exp_q.push_back(64'd1);  pop_check("coll9 rdBusyA", {63'd0, bus.rdBusyA});

    // Zero register
    next_cycle();
    bus.write = 1'b1; bus.wrAddr = 5'd31; bus.wrData = 64'hFFFF;
    bus.rsvValid = 1'b1; bus.rsvAddr = 5'd31;
    bus.rdAddrA = 5'd31; bus.rdAddrB = 5'd31;
    @(negedge clk);
    exp_q.push_back('0); pop_check("zr same rdDataA", bus.rdDataA);
    next_cycle();
    idle();
    @(negedge clk);
    exp_q.push_back('0); pop_check("zr rdDataB", bus.rdDataB);
    exp_q.push_back('0); pop_check("zr rdBusyA", {63'd0, bus.rdBusyA});

    // Forwarding behaviour on addr 5 (previously 0)
    next_cycle();
    bus.write = 1'b1; bus.wrAddr = 5'd5; bus.wrData = 64'h1234; bus.rdAddrA = 5'd5;
    @(negedge clk);
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(64'h1234);
`else
    exp_q.push_back('0);
`endif
    pop_check("byp same rdDataA", bus.rdDataA);
    next_cycle();
    idle();
    @(negedge clk);
    exp_q.push_back(64'h1234); pop_check("byp next rdDataA", bus.rdDataA);

    // Asynchronous reset mid-operation with nonzero contents
    bus.rdAddrA = 5'd3; bus.rdAddrB = 5'd9;
    bus.write = 1'b1; bus.wrAddr = 5'd6; bus.wrData = 64'h66;
    #1 rst = 1'b1;
    #1;
    exp_q.push_back('0); pop_check("async rst rdDataA", bus.rdDataA);
    exp_q.push_back('0); pop_check("async rst rdBusyB", {63'd0, bus.rdBusyB});
    @(posedge clk);                 // edge with rst high: write discarded
    @(negedge clk);
    rst = 1'b0;
    bus.wrAddr = 5'd4; bus.wrData = 64'h77;
    bus.rdAddrA = 5'd4; bus.rdAddrB = 5'd6;
    next_cycle();                   // first edge after reset: write taken
    idle();
    @(negedge clk);
    exp_q.push_back(64'h77); pop_check("post rst wr4", bus.rdDataA);
    exp_q.push_back('0);     pop_check("rst discard wr6", bus.rdDataB);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      next_cycle();
      bus.write    = ($urandom_range(0, 1) == 1);
      bus.wrAddr   = rand_addr();
      bus.wrData   = {$urandom, $urandom};
      bus.rsvValid = ($urandom_range(0, 2) == 0);
      bus.rsvAddr  = ($urandom_range(0, 3) == 0) ? bus.wrAddr : rand_addr();
      bus.rdAddrA  = ($urandom_range(0, 2) == 0) ? bus.wrAddr : rand_addr();
      bus.rdAddrB  = ($urandom_range(0, 3) == 0) ? bus.rdAddrA : rand_addr();
    end
    next_cycle();
    idle();
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, default 64: register width in bits.
REQ-002 Parameter ADDR_W, default 5: address width; depth is 2**ADDR_W.
REQ-003 Parameter HAS_ZR, default 1: if 1, the highest address is a hardwired zero register.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 write  in  1  write enable.
REQ-007 wrAddr  in  ADDR_W  write address.
REQ-008 wrData  in  DATA_W  write data.
REQ-009 rsvValid  in  1  reserve request: marks a register as awaiting a result.
REQ-010 rsvAddr  in  ADDR_W  address to reserve.
REQ-011 rdAddrA / rdAddrB  in  ADDR_W  read addresses for ports A and B.
REQ-012 rdDataA / rdDataB  out  DATA_W  read data; combinational from the address.
REQ-013 rdBusyA / rdBusyB  out  1  busy (reserved, not yet written) flag for the addressed register.

Function
REQ-014 The block SHALL hold 2**ADDR_W data registers and one busy bit per register.
REQ-015 When write=1, wrData SHALL be stored at wrAddr on the clock edge. The new value is visible on the read ports from the next cycle.
REQ-016 When write=1, the busy bit of wrAddr SHALL clear on the same edge.
REQ-017 When rsvValid=1, the busy bit of rsvAddr SHALL set on the clock edge.
REQ-018 When write and reserve target the same address in one cycle, the data SHALL be stored and the busy bit SHALL end set (reserve wins).
REQ-019 Writes and reserves to different addresses in one cycle SHALL both take effect.
REQ-020 With HAS_ZR=1, the register at address 2**ADDR_W-1 SHALL:
- read as 0;
- report busy 0;
- ignore writes and reserves.
REQ-021 Both read ports SHALL be independent. Identical addresses on A and B SHALL return identical data and busy values.
REQ-022 Read data and busy outputs SHALL depend only on the read address and stored state. With REGFILE_BYPASS_EN defined, they also depend on the current write inputs (REQ-027).

Reset
REQ-023 While rst=1, all data registers SHALL be 0 and all busy bits SHALL be 0, regardless of clk.
REQ-024 After reset, every read port SHALL output data 0 and busy 0 until the first write or reserve.
REQ-025 Reset asserted mid-operation SHALL discard any write or reserve on that cycle.
REQ-026 The first edge after rst deasserts SHALL perform normal writes and reserves.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined, when write=1 and rdAddrX==wrAddr (not the zero register), rdDataX SHALL equal wrData in the same cycle and rdBusyX SHALL be 0.
REQ-028 Without REGFILE_BYPASS_EN, reads SHALL return only stored state: one-cycle write-to-read latency, no forwarding logic.

Structure
REQ-029 Package regfile_pkg SHALL hold:
- default DATA_W and ADDR_W;
- a function returning the zero-register index for a given ADDR_W.
REQ-030 One sub-module, regfile_sb_rdport, SHALL implement a single read port (mux, busy lookup, optional bypass). It is instantiated twice.

Verification
REQ-031 Reset: assert rst with nonzero contents -> all rdData 0 and rdBusy 0 immediately (asynchronous).
REQ-032 Write/read: write 0xDEADBEEF_00000001 to addr 3, then read A=3, B=3 next cycle -> both return 0xDEADBEEF_00000001, busy 0.
REQ-033 Scoreboard: reserve addr 7 -> rdBusyA=1 at addr 7. Write 0x55 to addr 7 two cycles later -> busy 0 and data 0x55 on the following cycle.
REQ-034 Collision: in one cycle, write 0xAA and reserve on addr 9 -> next cycle data 0xAA, busy 1.
REQ-035 Zero register: write 0xFFFF to addr 31 and reserve addr 31 -> reads 0, busy 0.
REQ-036 Bypass: write 0x1234 to addr 5 with rdAddrA=5 in the same cycle:
- with REGFILE_BYPASS_EN -> rdDataA=0x1234 that cycle;
- without it -> old value that cycle, 0x1234 next cycle.
